// File: rtl/ram_read_arbiter_if.sv
// Request/response bundle for the two read clients of ram_read_arbiter.
// "master" is the client side and "slave" is the arbiter side.
interface ram_read_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic                  rsp0_valid;
    logic                  rsp0_ready;
    logic [DATA_WIDTH-1:0] rsp0_data;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic                  rsp1_valid;
    logic                  rsp1_ready;
    logic [DATA_WIDTH-1:0] rsp1_data;

    modport master (
        output req0_valid, req0_addr, rsp0_ready,
        output req1_valid, req1_addr, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data
    );

    modport slave (
        input  req0_valid, req0_addr, rsp0_ready,
        input  req1_valid, req1_addr, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data
    );
endinterface

// File: rtl/ram_read_arbiter.sv
// Round-robin sharing of one RAM read port between two clients.
// Each client has at most one read in flight and a one-entry response buffer.
module ram_read_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_read_arbiter_if.slave     bus,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);
    logic                  last_grant;
    logic [1:0]            req_valid;
    logic [1:0]            rsp_ready;
    logic [1:0]            in_flight;
    logic [1:0]            elig;
    logic [1:0]            cand;
    logic [1:0]            grant;
    logic [RD_LAT-1:0]     tag_vld_p;
    logic [RD_LAT-1:0]     tag_id_p;
    logic                  land_vld;
    logic                  land_id;
    logic [1:0]            rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q [2];

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

    always_comb begin
        in_flight = 2'b00;
        for (int s = 0; s < RD_LAT; s++) begin
            if (tag_vld_p[s]) in_flight[tag_id_p[s]] = 1'b1;
        end
    end

    // A client whose buffer is being popped this cycle may issue again at once.
    assign elig = ~in_flight & (~rsp_valid_q | rsp_ready);
    assign cand = rst ? 2'b00 : (req_valid & elig);

    always_comb begin
        grant = cand;
        if (cand == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign ram_rd_en      = |grant;

    always_comb begin
        ram_rd_addr = '0;
        if (grant[0])      ram_rd_addr = bus.req0_addr;
        else if (grant[1]) ram_rd_addr = bus.req1_addr;
    end

    always_ff @(posedge clk) begin
        if (rst)         last_grant <= 1'b1;
        else if (|grant) last_grant <= grant[1];
    end

    // Issue stage -> tag pipeline: one {valid,id} entry per RAM latency cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_p <= '0;
        end else begin
            tag_vld_p[0] <= |grant;
            for (int s = 1; s < RD_LAT; s++) tag_vld_p[s] <= tag_vld_p[s-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_id_p[0] <= grant[1];
        for (int s = 1; s < RD_LAT; s++) tag_id_p[s] <= tag_id_p[s-1];
    end

    assign land_vld = tag_vld_p[RD_LAT-1];
    assign land_id  = tag_id_p[RD_LAT-1];

    // Tag tail -> response buffers: RAM data is captured for the tagged client
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q   <= 2'b00;
            rsp_data_q[0] <= '0;
            rsp_data_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (land_vld && (land_id == 1'(i))) begin
                    rsp_valid_q[i] <= 1'b1;
                    rsp_data_q[i]  <= ram_rd_data;
                end else if (rsp_valid_q[i] && rsp_ready[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.rsp0_valid = rsp_valid_q[0];
    assign bus.rsp1_valid = rsp_valid_q[1];
    assign bus.rsp0_data  = rsp_data_q[0];
    assign bus.rsp1_data  = rsp_data_q[1];

    a_one_grant: assert property (@(posedge clk) disable iff (rst)
        !(grant[0] && grant[1]));

    a_no_overrun: assert property (@(posedge clk) disable iff (rst)
        land_vld |-> !rsp_valid_q[land_id]);
endmodule

// File: tb/tb_ram_read_arbiter.sv
// Bench for ram_read_arbiter: runs an RD_LAT=1 and an RD_LAT=3 instance on the
// same client stimulus, checking both against a transaction-level model.
module tb_ram_read_arbiter;
    localparam int AW = 6;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [AW-1:0] req_addr [2];
    logic [1:0]    rsp_ready;

    logic          en_a, en_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] pipe_b [3];

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    ram_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
    ram_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    assign bus_a.req0_valid = req_valid[0];
    assign bus_a.req1_valid = req_valid[1];
    assign bus_a.req0_addr  = req_addr[0];
    assign bus_a.req1_addr  = req_addr[1];
    assign bus_a.rsp0_ready = rsp_ready[0];
    assign bus_a.rsp1_ready = rsp_ready[1];
    assign bus_b.req0_valid = req_valid[0];
    assign bus_b.req1_valid = req_valid[1];
    assign bus_b.req0_addr  = req_addr[0];
    assign bus_b.req1_addr  = req_addr[1];
    assign bus_b.rsp0_ready = rsp_ready[0];
    assign bus_b.rsp1_ready = rsp_ready[1];

    ram_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .ram_rd_en(en_a), .ram_rd_addr(addr_a), .ram_rd_data(rdata_a)
    );

    ram_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .ram_rd_en(en_b), .ram_rd_addr(addr_b), .ram_rd_data(pipe_b[2])
    );

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (a == 6'd5) return 64'hA5;
        return {32'hC0DE_0000, 26'd0, a} + {26'd0, a, 32'd0};
    endfunction

    // RAM behaviour: contents from mem_val, read data after 1 resp. 3 cycles
    always @(posedge clk) rdata_a <= en_a ? mem_val(addr_a) : '0;
    always @(posedge clk) begin
        pipe_b[0] <= en_b ? mem_val(addr_b) : '0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Transaction-level model: per client an outstanding read with the cycle its
    // data lands, plus a one-entry buffer.
    int            lat     [2] = '{1, 3};
    bit            m_lg    [2] = '{1'b1, 1'b1};
    bit            m_inf   [2][2];
    int            m_land  [2][2];
    logic [AW-1:0] m_laddr [2][2];
    bit            m_bufv  [2][2];
    logic [DW-1:0] m_bufd  [2][2];

    task automatic model_cycle(input int d, input string p,
                               input logic rdy0, input logic rdy1, input logic en,
                               input logic [AW-1:0] addr, input logic v0, input logic v1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bit c [2];
        bit g [2];
        logic [AW-1:0] exp_addr;
        for (int i = 0; i < 2; i++)
            c[i] = !rst && req_valid[i] && !m_inf[d][i] && (!m_bufv[d][i] || rsp_ready[i]);
        if (c[0] && c[1]) begin
            g[0] = m_lg[d];
            g[1] = !m_lg[d];
        end else begin
            g[0] = c[0];
            g[1] = c[1];
        end
        exp_addr = g[0] ? req_addr[0] : (g[1] ? req_addr[1] : '0);
        check({p, "_req0_ready"}, rdy0, g[0]);
        check({p, "_req1_ready"}, rdy1, g[1]);
        check({p, "_rd_en"}, en, g[0] | g[1]);
        check({p, "_rd_addr"}, addr, exp_addr);
        check({p, "_rsp0_valid"}, v0, m_bufv[d][0]);
        check({p, "_rsp1_valid"}, v1, m_bufv[d][1]);
        if (m_bufv[d][0]) check({p, "_rsp0_data"}, d0, m_bufd[d][0]);
        if (m_bufv[d][1]) check({p, "_rsp1_data"}, d1, m_bufd[d][1]);

        if (rst) begin
            m_lg[d] = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_inf[d][i]  = 1'b0;
                m_bufv[d][i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_bufv[d][i] && rsp_ready[i]) m_bufv[d][i] = 1'b0;
                if (m_inf[d][i] && cyc == m_land[d][i]) begin
                    m_bufv[d][i] = 1'b1;
                    m_bufd[d][i] = mem_val(m_laddr[d][i]);
                    m_inf[d][i]  = 1'b0;
                end
                if (g[i]) begin
                    m_inf[d][i]   = 1'b1;
                    m_land[d][i]  = cyc + lat[d];
                    m_laddr[d][i] = req_addr[i];
                end
            end
            if (g[0] || g[1]) m_lg[d] = g[1];
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            model_cycle(0, "L1", bus_a.req0_ready, bus_a.req1_ready, en_a, addr_a,
                        bus_a.rsp0_valid, bus_a.rsp1_valid, bus_a.rsp0_data, bus_a.rsp1_data);
            model_cycle(1, "L3", bus_b.req0_ready, bus_b.req1_ready, en_b, addr_b,
                        bus_b.rsp0_valid, bus_b.rsp1_valid, bus_b.rsp0_data, bus_b.rsp1_data);
            cyc++;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b01;
        req_addr[0] = 6'd5;
        req_addr[1] = 6'd0;
        rsp_ready = 2'b00;

        // reset: valid request is not accepted while rst is high
        @(negedge clk);
        check("rst_req0_ready_L1", bus_a.req0_ready, 0);
        check("rst_rd_en_L3", en_b, 0);
        check("rst_rsp0_valid_L1", bus_a.rsp0_valid, 0);
        check("rst_rsp1_valid_L3", bus_b.rsp1_valid, 0);
        nxt();

        // single read of address 5
        rst = 1'b0;
        @(negedge clk);
        check("single_grant_L1", bus_a.req0_ready, 1);
        check("single_addr_L1", addr_a, 5);
        check("single_grant_L3", bus_b.req0_ready, 1);
        nxt();
        req_valid = 2'b00;
        @(negedge clk);
        check("single_early_L1", bus_a.rsp0_valid, 0);
        nxt();
        @(negedge clk);
        check("single_rsp_valid_L1", bus_a.rsp0_valid, 1);
        check("single_rsp_data_L1", bus_a.rsp0_data, 64'hA5);
        check("single_early_L3", bus_b.rsp0_valid, 0);
        nxt();
        @(negedge clk);
        check("single_early2_L3", bus_b.rsp0_valid, 0);
        nxt();
        @(negedge clk);
        check("single_rsp_valid_L3", bus_b.rsp0_valid, 1);
        check("single_rsp_data_L3", bus_b.rsp0_data, 64'hA5);
        check("single_hold_L1", bus_a.rsp0_data, 64'hA5);
        nxt();
        rsp_ready = 2'b11;
        repeat (2) nxt();
        rsp_ready = 2'b00;

        // tie after reset, then alternation at full throughput
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        rsp_ready = 2'b11;
        for (int k = 0; k < 8; k++) begin
            req_valid = 2'b11;
            req_addr[0] = AW'(2 * k);
            req_addr[1] = AW'(2 * k + 1);
            @(negedge clk);
            check("alt_req0_ready_L1", bus_a.req0_ready, (k % 2) == 0);
            check("alt_req1_ready_L1", bus_a.req1_ready, (k % 2) == 1);
            check("alt_rd_en_L1", en_a, 1);
            nxt();
        end
        req_valid = 2'b00;
        repeat (6) nxt();

        // backpressure on client 0
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        req_addr[0] = 6'd9;
        @(negedge clk);
        check("bp_first_grant_L1", bus_a.req0_ready, 1);
        nxt();
        nxt();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_ready_low_L1", bus_a.req0_ready, 0);
            check("bp_valid_L1", bus_a.rsp0_valid, 1);
            check("bp_data_L1", bus_a.rsp0_data, mem_val(6'd9));
            nxt();
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        check("bp_release_L1", bus_a.req0_ready, 1);
        check("bp_release_L3", bus_b.req0_ready, 1);
        nxt();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (6) nxt();

        // reset while a client-1 read is in flight
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        req_addr[1] = 6'd33;
        @(negedge clk);
        check("mid_grant1_L1", bus_a.req1_ready, 1);
        check("mid_grant1_L3", bus_b.req1_ready, 1);
        nxt();
        req_valid = 2'b00;
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("mid_rsp1_L1", bus_a.rsp1_valid, 0);
            check("mid_rsp1_L3", bus_b.rsp1_valid, 0);
            nxt();
        end
        req_valid = 2'b11;
        req_addr[0] = 6'd20;
        req_addr[1] = 6'd21;
        @(negedge clk);
        check("mid_tie0_L1", bus_a.req0_ready, 1);
        check("mid_tie1_L1", bus_a.req1_ready, 0);
        check("mid_tie0_L3", bus_b.req0_ready, 1);
        nxt();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (6) nxt();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
